// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths and scheduler state encoding for the sprite scheduler.
package sprite_pkg;
    localparam int COORD_W = 12;
    localparam int FRAME_W = 16;
    typedef enum logic [1:0] {IDLE, CALC, WRITE, NEXT} sched_state_t;
endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: next position/direction along one axis for one frame step.
// SPRITE_SCHED_BOUNCE_EN selects bounce at the edges; otherwise positions wrap forward.
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int LIMIT    = 480,
    parameter int SPRITE_W = 32
) (
    input  logic [COORD_W-1:0] pos,
    input  logic               dir,
    input  logic [3:0]         step,
    output logic [COORD_W-1:0] next_pos,
    output logic               next_dir
);
    logic [COORD_W:0] sum;
    assign sum = {1'b0, pos} + {{(COORD_W-3){1'b0}}, step};
`ifdef SPRITE_SCHED_BOUNCE_EN
    localparam logic [COORD_W-1:0] MAX_POS = COORD_W'(LIMIT - SPRITE_W);
    logic hit_max, hit_min;
    assign hit_max  = sum >= {1'b0, MAX_POS};
    assign hit_min  = {{(COORD_W-4){1'b0}}, step} > pos;
    assign next_pos = dir ? (hit_max ? MAX_POS : sum[COORD_W-1:0])
                          : (hit_min ? '0 : pos - {{(COORD_W-4){1'b0}}, step});
    assign next_dir = dir ? !hit_max : hit_min;
`else
    localparam logic [COORD_W:0] LIM = (COORD_W+1)'(LIMIT);
    assign next_pos = sum >= LIM ? COORD_W'(sum - LIM) : sum[COORD_W-1:0];
    // Wrapping motion only ever moves forward; dir stays a port so both builds share one interface.
    assign next_dir = dir | 1'b1;
`endif
endmodule

// File: rtl/sprite_sched.sv
// sprite_sched: per-vblank sprite position sequencer writing attributes over a valid/ready port.
// Edge behaviour selected by SPRITE_SCHED_BOUNCE_EN (bounce) or its absence (wrap).
module sprite_sched
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 4,
    parameter int H_ACTIVE     = 480,
    parameter int V_ACTIVE     = 272,
    parameter int SPRITE_W     = 32,
    parameter int ENABLE_SHIFT = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [COORD_W-1:0]             vy,
    input  logic                           run,
    input  logic [3:0]                     step,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [$clog2(NUM_SPRITES)-1:0] wr_idx,
    output logic [COORD_W-1:0]             wr_x,
    output logic [COORD_W-1:0]             wr_y,
    output logic [NUM_SPRITES-1:0]         enables,
    output logic [FRAME_W-1:0]             frame_cnt,
    output logic                           busy,
    output logic                           overrun
);
    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int CNT_W = $clog2(NUM_SPRITES + 1);
    sched_state_t state, state_nx;
    logic [COORD_W-1:0] x [NUM_SPRITES];
    logic [COORD_W-1:0] y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] dx, dy;
    logic [CNT_W-1:0] active_count;
    logic [COORD_W-1:0] calc_x, calc_y;
    logic calc_dx, calc_dy, wr_dx, wr_dy;
    logic active_q, in_active, vblank, last;
    assign in_active = vy < COORD_W'(V_ACTIVE);
    assign vblank    = !in_active && active_q;
    assign last      = wr_idx == IDX_W'(NUM_SPRITES - 1);
    sprite_axis_step #(.LIMIT(H_ACTIVE), .SPRITE_W(SPRITE_W)) u_x (
        .pos(x[wr_idx]), .dir(dx[wr_idx]), .step(step), .next_pos(calc_x), .next_dir(calc_dx)
    );
    sprite_axis_step #(.LIMIT(V_ACTIVE), .SPRITE_W(SPRITE_W)) u_y (
        .pos(y[wr_idx]), .dir(dy[wr_idx]), .step(step), .next_pos(calc_y), .next_dir(calc_dy)
    );
    always_comb begin
        state_nx = (state == IDLE)  ? ((vblank && run) ? CALC : IDLE)
                 : (state == CALC)  ? WRITE
                 : (state == WRITE) ? (wr_ready ? NEXT : WRITE)
                 : (last ? IDLE : CALC);
        busy     = state != IDLE;
        wr_valid = state == WRITE;
    end
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) enables[i] = i < int'(active_count);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            active_q     <= 1'b0;
            frame_cnt    <= '0;
            active_count <= CNT_W'(1);
            overrun      <= 1'b0;
            wr_idx       <= '0;
            wr_x         <= '0;
            wr_y         <= '0;
            wr_dx        <= 1'b1;
            wr_dy        <= 1'b1;
            dx           <= '1;
            dy           <= '1;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x[i] <= COORD_W'(i * SPRITE_W);
                y[i] <= COORD_W'(i * SPRITE_W);
            end
        end else begin
            state    <= state_nx;
            active_q <= in_active;
            if (vblank) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
                if (&frame_cnt[ENABLE_SHIFT-1:0])
                    active_count <= (active_count == CNT_W'(NUM_SPRITES)) ? CNT_W'(1) : active_count + CNT_W'(1);
            end
            // Leaving vblank with a pass still in flight means the writes spilled into active video.
            if (busy && in_active && !active_q) overrun <= 1'b1;
            if (state == CALC) begin
                wr_x  <= calc_x;
                wr_y  <= calc_y;
                wr_dx <= calc_dx;
                wr_dy <= calc_dy;
            end
            if (wr_valid && wr_ready) begin
                x[wr_idx]  <= wr_x;
                y[wr_idx]  <= wr_y;
                dx[wr_idx] <= wr_dx;
                dy[wr_idx] <= wr_dy;
            end
            if (state == NEXT) wr_idx <= last ? '0 : wr_idx + IDX_W'(1);
        end
    end
endmodule

// File: tb/tb_sprite_sched.sv
// tb_sprite_sched: scoreboard bench for sprite_sched (default 4 sprites, 480x272, 32px sprites).
// Expected writes come from a behavioural motion model, honouring SPRITE_SCHED_BOUNCE_EN.
module tb_sprite_sched;
    logic        clock, reset, run, wr_ready, wr_valid, busy, overrun;
    logic [11:0] vy, wr_x, wr_y;
    logic [3:0]  step, enables;
    logic [1:0]  wr_idx;
    logic [15:0] frame_cnt;

    typedef struct {
        logic [1:0]  idx;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    exp_t        q[$];
    int          mx[4], my[4];
    bit          mdx[4], mdy[4];
    logic [15:0] fc;
    logic [11:0] last_x0;
    int          tests = 0;
    int          fails = 0;

    sprite_sched dut (
        .clock(clock), .reset(reset), .vy(vy), .run(run), .step(step),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .enables(enables), .frame_cnt(frame_cnt), .busy(busy), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic void axis(input int p, input bit d, input int s, input int lim,
                                 output int np, output bit nd);
`ifdef SPRITE_SCHED_BOUNCE_EN
        int mx_pos = lim - 32;
        if (d) begin
            np = (p + s >= mx_pos) ? mx_pos : p + s;
            nd = (p + s < mx_pos);
        end else begin
            np = (s > p) ? 0 : p - s;
            nd = (s > p);
        end
`else
        np = (p + s >= lim) ? p + s - lim : p + s;
        nd = 1'b1;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1; vy = 12'd0; run = 1'b0; wr_ready = 1'b1; step = 4'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mx[i] = i * 32; my[i] = i * 32; mdx[i] = 1'b1; mdy[i] = 1'b1;
        end
        fc = 16'd0;
        q.delete();
    endtask

    task automatic push_pass(input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            int nx, ny;
            bit ndx, ndy;
            axis(mx[i], mdx[i], int'(s), 480, nx, ndx);
            axis(my[i], mdy[i], int'(s), 272, ny, ndy);
            mx[i] = nx; my[i] = ny; mdx[i] = ndx; mdy[i] = ndy;
            q.push_back('{2'(i), 12'(nx), 12'(ny)});
        end
    endtask

    task automatic entry();
        @(negedge clock) vy = 12'd271;
        @(negedge clock) vy = 12'd272;
        fc = fc + 16'd1;
        @(negedge clock);
    endtask

    task automatic wait_pass();
        int n = 0;
        while ((q.size() > 0 || busy) && n < 400) begin
            if (wr_valid && wr_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_write: idx=%0d x=%0d y=%0d, none expected", wr_idx, wr_x, wr_y);
                end else begin
                    exp_t e = q.pop_front();
                    if (wr_idx !== e.idx || wr_x !== e.x || wr_y !== e.y) begin
                        fails++;
                        $display("FAIL write: got idx=%0d x=%0d y=%0d, expected idx=%0d x=%0d y=%0d",
                                 wr_idx, wr_x, wr_y, e.idx, e.x, e.y);
                    end
                end
                if (wr_idx == 2'd0) last_x0 = wr_x;
            end
            n++;
            @(negedge clock);
        end
        tests++;
        if (n >= 400) begin
            fails++;
            $display("FAIL pass_timeout: busy=%0d pending=%0d, expected idle with none pending", busy, q.size());
        end
    endtask

    task automatic do_pass(input logic [3:0] s, input bit drop_run);
        step = s; run = 1'b1;
        push_pass(s);
        entry();
        if (drop_run) run = 1'b0;
        wait_pass();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (busy !== 1'b0 || overrun !== 1'b0 || wr_idx !== 2'd0 || wr_x !== 12'd0 || wr_y !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%0d overrun=%0d idx=%0d x=%0d y=%0d, expected all 0",
                     busy, overrun, wr_idx, wr_x, wr_y);
        end
        repeat (100) begin
            @(negedge clock);
            tests++;
            if (enables !== 4'b0001 || frame_cnt !== 16'd0 || wr_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: enables=%b frame_cnt=%0d wr_valid=%0d, expected 0001/0/0",
                         enables, frame_cnt, wr_valid);
            end
        end
    endtask

    task automatic test_pass();
        do_pass(4'd4, 1'b0);
        tests++;
        if (frame_cnt !== fc || busy !== 1'b0) begin
            fails++;
            $display("FAIL pass_end: frame_cnt=%0d busy=%0d, expected %0d/0", frame_cnt, busy, fc);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        wr_ready = 1'b0; step = 4'd3; run = 1'b1;
        push_pass(4'd3);
        entry();
        while (!wr_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        repeat (10) begin
            tests++;
            if (wr_valid !== 1'b1 || wr_idx !== q[0].idx || wr_x !== q[0].x || wr_y !== q[0].y) begin
                fails++;
                $display("FAIL backpressure: valid=%0d idx=%0d x=%0d y=%0d, expected 1/%0d/%0d/%0d",
                         wr_valid, wr_idx, wr_x, wr_y, q[0].idx, q[0].x, q[0].y);
            end
            @(negedge clock);
        end
        wr_ready = 1'b1;
        wait_pass();
    endtask

    task automatic test_run_drop();
        do_pass(4'd5, 1'b1);
        repeat (5) @(negedge clock);
        tests++;
        if (busy !== 1'b0 || wr_valid !== 1'b0) begin
            fails++;
            $display("FAIL run_drop_idle: busy=%0d wr_valid=%0d, expected 0/0", busy, wr_valid);
        end
    endtask

    task automatic test_overrun();
        wr_ready = 1'b0; step = 4'd2; run = 1'b1;
        push_pass(4'd2);
        entry();
        repeat (3) @(negedge clock);
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_early: overrun=%0d, expected 0", overrun);
        end
        vy = 12'd0;
        @(negedge clock);
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: overrun=%0d, expected 1", overrun);
        end
        entry();
        tests++;
        if (busy !== 1'b1 || frame_cnt !== fc) begin
            fails++;
            $display("FAIL busy_vblank: busy=%0d frame_cnt=%0d, expected 1/%0d", busy, frame_cnt, fc);
        end
        wr_ready = 1'b1;
        wait_pass();
        repeat (10) @(negedge clock);
        tests++;
        if (busy !== 1'b0 || wr_valid !== 1'b0 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky: busy=%0d wr_valid=%0d overrun=%0d, expected 0/0/1",
                     busy, wr_valid, overrun);
        end
    endtask

    task automatic test_edge();
`ifdef SPRITE_SCHED_BOUNCE_EN
        int          target = 446;
        logic [11:0] exp1 = 12'd448, exp2 = 12'd444;
`else
        int          target = 478;
        logic [11:0] exp1 = 12'd2, exp2 = 12'd6;
`endif
        do_reset();
        while (mx[0] != target) do_pass(4'((target - mx[0] > 15) ? 15 : target - mx[0]), 1'b0);
        do_pass(4'd4, 1'b0);
        tests++;
        if (last_x0 !== exp1) begin
            fails++;
            $display("FAIL edge_first: wr_x=%0d, expected %0d", last_x0, exp1);
        end
        do_pass(4'd4, 1'b0);
        tests++;
        if (last_x0 !== exp2) begin
            fails++;
            $display("FAIL edge_second: wr_x=%0d, expected %0d", last_x0, exp2);
        end
    endtask

    task automatic test_enables();
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            entry();
            if (k == 63 || k == 64 || k == 128 || k == 192 || k == 256) begin
                logic [3:0] e;
                e = (k == 64) ? 4'b0011 : (k == 128) ? 4'b0111 : (k == 192) ? 4'b1111 : 4'b0001;
                tests++;
                if (enables !== e || frame_cnt !== fc) begin
                    fails++;
                    $display("FAIL enables_%0d: enables=%b frame_cnt=%0d, expected %b/%0d",
                             k, enables, frame_cnt, e, fc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_backpressure();
        test_run_drop();
        test_overrun();
        test_edge();
        test_enables();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
